// File: rtl/logic_unit_arbiter_if.sv
// Request/response bundle for the shared logic unit: two requester channels
// plus one response channel. The master side is the requesters and consumer.
interface logic_unit_arbiter_if #(
   parameter int unsigned WIDTH = 20
);
   logic             req0_valid;
   logic             req0_ready;
   logic [1:0]       req0_op;
   logic [WIDTH-1:0] req0_a;
   logic [WIDTH-1:0] req0_b;
   logic             req1_valid;
   logic             req1_ready;
   logic [1:0]       req1_op;
   logic [WIDTH-1:0] req1_a;
   logic [WIDTH-1:0] req1_b;
   logic             rsp_valid;
   logic             rsp_ready;
   logic             rsp_id;
   logic [WIDTH-1:0] rsp_data;
   logic             rsp_zero;

   modport master (
      output req0_valid, req0_op, req0_a, req0_b,
      output req1_valid, req1_op, req1_a, req1_b,
      output rsp_ready,
      input  req0_ready, req1_ready,
      input  rsp_valid, rsp_id, rsp_data, rsp_zero
   );

   modport slave (
      input  req0_valid, req0_op, req0_a, req0_b,
      input  req1_valid, req1_op, req1_a, req1_b,
      input  rsp_ready,
      output req0_ready, req1_ready,
      output rsp_valid, rsp_id, rsp_data, rsp_zero
   );
endinterface

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one bitwise logic unit (AND/OR/XOR/NOT + zero
// flag) between two requesters; one operation in flight, held until accepted.
module logic_unit_arbiter #(
   parameter int unsigned WIDTH = 20
) (
   input logic                 clk,
   input logic                 rst_n,
   logic_unit_arbiter_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [1:0]       op_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             id_q;
   logic             rr_last;
   logic             grant_any;
   logic             grant_id;
   logic             take;
   logic [WIDTH-1:0] result;
   logic             rsp_valid_q;
   logic             rsp_id_q;
   logic [WIDTH-1:0] rsp_data_q;
   logic             rsp_zero_q;

   // A lone requester wins outright; a contest goes to the one not served last.
   always_comb begin
      grant_any = bus.req0_valid | bus.req1_valid;
      if (bus.req0_valid && bus.req1_valid) grant_id = ~rr_last;
      else                                  grant_id = ~bus.req0_valid;
   end

   // Readies are gated by rst_n so nothing is offered while reset is held.
   always_comb begin
      state_nxt      = state;
      take           = 1'b0;
      bus.req0_ready = 1'b0;
      bus.req1_ready = 1'b0;
      unique case (state)
         IDLE: begin
            if (rst_n && grant_any) begin
               take           = 1'b1;
               bus.req0_ready = ~grant_id;
               bus.req1_ready = grant_id;
               state_nxt      = EXEC;
            end
         end
         EXEC:    state_nxt = RESP;
         RESP:    if (bus.rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      unique case (op_q)
         2'b00:   result = a_q & b_q;
         2'b01:   result = a_q | b_q;
         2'b10:   result = a_q ^ b_q;
         default: result = ~a_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q        <= '0;
         a_q         <= '0;
         b_q         <= '0;
         id_q        <= 1'b0;
         rr_last     <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= 1'b0;
         rsp_data_q  <= '0;
         rsp_zero_q  <= 1'b0;
      end else begin
         if (take) begin
            op_q    <= grant_id ? bus.req1_op : bus.req0_op;
            a_q     <= grant_id ? bus.req1_a  : bus.req0_a;
            b_q     <= grant_id ? bus.req1_b  : bus.req0_b;
            id_q    <= grant_id;
            rr_last <= grant_id;
         end
         if (state == EXEC) begin
            rsp_data_q  <= result;
            rsp_zero_q  <= (result == '0);
            rsp_id_q    <= id_q;
            rsp_valid_q <= 1'b1;
         end else if (state == RESP && bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
         end
      end
   end

   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_id    = rsp_id_q;
   assign bus.rsp_data  = rsp_data_q;
   assign bus.rsp_zero  = rsp_zero_q;
endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Scenario bench for logic_unit_arbiter: handshakes push expected results into
// a scoreboard queue, accepted responses pop and compare against it.
module tb_logic_unit_arbiter;
   localparam int unsigned W = 20;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic_unit_arbiter_if #(.WIDTH(W)) bus ();

   logic_unit_arbiter #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct packed {
      logic         id;
      logic [W-1:0] data;
      logic         zero;
   } exp_t;

   exp_t sb[$];
   exp_t sb_head;
   int   vectors     = 0;
   int   miscompares = 0;

   function automatic logic [W-1:0] model(input logic [1:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
      case (op)
         2'b00:   return a & b;
         2'b01:   return a | b;
         2'b10:   return a ^ b;
         default: return ~a;
      endcase
   endfunction

   // Scoreboard: push on every handshake, pop on every accepted response.
   always @(negedge clk) begin
      if (!rst_n) begin
         sb.delete();
      end else begin
         vectors++;
         if (bus.req0_ready && bus.req1_ready) begin
            miscompares++;
            $display("FAIL one_ready: req0_ready=%b req1_ready=%b, required at most one high",
                     bus.req0_ready, bus.req1_ready);
         end
         if (bus.rsp_valid && bus.rsp_ready) begin
            vectors++;
            if (sb.size() == 0) begin
               miscompares++;
               $display("FAIL sb_empty: response id=%0d data=%h with no request outstanding",
                        bus.rsp_id, bus.rsp_data);
            end else begin
               sb_head = sb.pop_front();
               if ({bus.rsp_id, bus.rsp_data, bus.rsp_zero} !== sb_head) begin
                  miscompares++;
                  $display("FAIL sb_rsp: got id=%0d data=%h zero=%b, required id=%0d data=%h zero=%b",
                           bus.rsp_id, bus.rsp_data, bus.rsp_zero,
                           sb_head.id, sb_head.data, sb_head.zero);
               end
            end
         end
         if (bus.req0_valid && bus.req0_ready)
            sb.push_back('{1'b0, model(bus.req0_op, bus.req0_a, bus.req0_b),
                           model(bus.req0_op, bus.req0_a, bus.req0_b) == '0});
         if (bus.req1_valid && bus.req1_ready)
            sb.push_back('{1'b1, model(bus.req1_op, bus.req1_a, bus.req1_b),
                           model(bus.req1_op, bus.req1_a, bus.req1_b) == '0});
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input bit id, input bit v, input logic [1:0] op,
                          input logic [W-1:0] a, input logic [W-1:0] b);
      if (!id) begin
         bus.req0_valid = v; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
      end else begin
         bus.req1_valid = v; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
      end
   endtask

   task automatic wait_ready(input bit id, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (id ? bus.req1_ready : bus.req0_ready) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_rsp(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (bus.rsp_valid) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic drain();
      bit done = 1'b0;
      bus.rsp_ready = 1'b1;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (!bus.rsp_valid && sb.size() == 0) begin
            done = 1'b1;
            break;
         end
      end
      vectors++;
      if (!done) begin
         miscompares++;
         $display("FAIL drain: rsp_valid=%b pending=%0d after 30 cycles, required 0/0",
                  bus.rsp_valid, sb.size());
      end
      tick();
      bus.rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.rsp_ready = 1'b0;
      set_req(0, 1, 2'b01, 20'h00001, 20'h00002);
      set_req(1, 1, 2'b00, 20'hFFFFF, 20'h0F0F0);
      repeat (3) @(negedge clk);
      vectors++;
      if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_zero, bus.req0_ready, bus.req1_ready} !== '0) begin
         miscompares++;
         $display("FAIL reset_outputs: valid=%b id=%b data=%h zero=%b rdy0=%b rdy1=%b, required all 0",
                  bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_zero, bus.req0_ready, bus.req1_ready);
      end
      tick();
      rst_n = 1'b1;
      @(negedge clk);
      vectors++;
      if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
         miscompares++;
         $display("FAIL reset_first_grant: rdy0=%b rdy1=%b, required 1 0", bus.req0_ready, bus.req1_ready);
      end
      tick();
      set_req(0, 0, 2'b00, '0, '0);
      set_req(1, 0, 2'b00, '0, '0);
      drain();
   endtask

   task automatic test_xor();
      bit ok;
      set_req(0, 1, 2'b10, 20'hF0F0F, 20'h0F0F0);
      wait_ready(0, ok);
      vectors++;
      if (!ok) begin
         miscompares++;
         $display("FAIL xor_grant: req0_ready=0 for 10 cycles, required 1");
      end
      tick();
      set_req(0, 0, 2'b00, '0, '0);
      @(negedge clk);
      vectors++;
      if (bus.rsp_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL xor_latency_early: rsp_valid=%b one cycle after handshake, required 0", bus.rsp_valid);
      end
      @(negedge clk);
      vectors++;
      if (bus.rsp_valid !== 1'b1) begin
         miscompares++;
         $display("FAIL xor_latency: rsp_valid=%b two cycles after handshake, required 1", bus.rsp_valid);
      end
      vectors++;
      if ({bus.rsp_id, bus.rsp_data, bus.rsp_zero} !== {1'b0, 20'hFFFFF, 1'b0}) begin
         miscompares++;
         $display("FAIL xor_result: id=%0d data=%h zero=%b, required id=0 data=fffff zero=0",
                  bus.rsp_id, bus.rsp_data, bus.rsp_zero);
      end
      tick();
      drain();
   endtask

   task automatic test_req1();
      bit ok;
      logic [1:0]   ops  [2] = '{2'b10, 2'b11};
      logic [W-1:0] as   [2] = '{20'h12345, 20'h00000};
      logic [W-1:0] bs   [2] = '{20'h12345, 20'hABCDE};
      logic [W-1:0] exps [2] = '{20'h00000, 20'hFFFFF};
      logic         zs   [2] = '{1'b1, 1'b0};
      for (int k = 0; k < 2; k++) begin
         set_req(1, 1, ops[k], as[k], bs[k]);
         wait_ready(1, ok);
         vectors++;
         if (!ok) begin
            miscompares++;
            $display("FAIL req1_grant_%0d: req1_ready=0 for 10 cycles, required 1", k);
         end
         tick();
         set_req(1, 0, 2'b00, '0, '0);
         wait_rsp(ok);
         vectors++;
         if (!ok || {bus.rsp_id, bus.rsp_data, bus.rsp_zero} !== {1'b1, exps[k], zs[k]}) begin
            miscompares++;
            $display("FAIL req1_result_%0d: valid=%b id=%0d data=%h zero=%b, required id=1 data=%h zero=%b",
                     k, bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_zero, exps[k], zs[k]);
         end
         tick();
         drain();
      end
   endtask

   task automatic test_fairness();
      int grants = 0;
      int rsps   = 0;
      bit exp_id = 1'b0;
      bit g0, g1;
      bus.rsp_ready = 1'b1;
      set_req(0, 1, 2'($urandom_range(0, 3)), W'($urandom), W'($urandom));
      set_req(1, 1, 2'($urandom_range(0, 3)), W'($urandom), W'($urandom));
      for (int c = 0; c < 80 && rsps < 8; c++) begin
         @(negedge clk);
         g0 = bus.req0_valid && bus.req0_ready;
         g1 = bus.req1_valid && bus.req1_ready;
         if (bus.rsp_valid && bus.rsp_ready) begin
            vectors++;
            if (bus.rsp_id !== exp_id) begin
               miscompares++;
               $display("FAIL fair_order_%0d: rsp_id=%0d, required %0d", rsps, bus.rsp_id, exp_id);
            end
            exp_id = ~exp_id;
            rsps++;
         end
         tick();
         if (g0 || g1) grants++;
         if (g0) set_req(0, 1, 2'($urandom_range(0, 3)), W'($urandom), W'($urandom));
         if (g1) set_req(1, 1, 2'($urandom_range(0, 3)), W'($urandom), W'($urandom));
         if (grants >= 8) begin
            bus.req0_valid = 1'b0;
            bus.req1_valid = 1'b0;
         end
      end
      vectors++;
      if (rsps != 8) begin
         miscompares++;
         $display("FAIL fair_count: %0d responses, required 8", rsps);
      end
      drain();
   endtask

   task automatic test_backpressure();
      bit ok;
      bus.rsp_ready = 1'b0;
      set_req(0, 1, 2'b00, 20'hAAAAA, 20'hFFFFF);
      wait_ready(0, ok);
      vectors++;
      if (!ok) begin
         miscompares++;
         $display("FAIL bp_grant: req0_ready=0 for 10 cycles, required 1");
      end
      tick();
      set_req(0, 0, 2'b00, '0, '0);
      set_req(1, 1, 2'b01, 20'h00012, 20'h00034);
      wait_rsp(ok);
      for (int i = 0; i < 5; i++) begin
         vectors++;
         if ({bus.rsp_valid, bus.rsp_data, bus.req0_ready, bus.req1_ready} !== {1'b1, 20'hAAAAA, 2'b00}) begin
            miscompares++;
            $display("FAIL bp_hold_%0d: valid=%b data=%h rdy0=%b rdy1=%b, required 1 aaaaa 0 0",
                     i, bus.rsp_valid, bus.rsp_data, bus.req0_ready, bus.req1_ready);
         end
         tick();
         if (i == 4) bus.rsp_ready = 1'b1;
         @(negedge clk);
      end
      vectors++;
      if ({bus.rsp_valid, bus.rsp_data} !== {1'b1, 20'hAAAAA}) begin
         miscompares++;
         $display("FAIL bp_accept: valid=%b data=%h, required 1 aaaaa", bus.rsp_valid, bus.rsp_data);
      end
      tick();
      bus.rsp_ready = 1'b0;
      @(negedge clk);
      vectors++;
      if ({bus.req0_ready, bus.req1_ready} !== 2'b01) begin
         miscompares++;
         $display("FAIL bp_next_grant: rdy0=%b rdy1=%b, required 0 1", bus.req0_ready, bus.req1_ready);
      end
      tick();
      set_req(1, 0, 2'b00, '0, '0);
      drain();
   endtask

   task automatic test_reset_mid();
      bit ok;
      // Phase 1: reset while a req1 op is executing.
      set_req(1, 1, 2'b01, 20'h0F0F0, 20'h00F00);
      wait_ready(1, ok);
      vectors++;
      if (!ok) begin
         miscompares++;
         $display("FAIL rmid_grant: req1_ready=0 for 10 cycles, required 1");
      end
      tick();
      rst_n = 1'b0;
      set_req(0, 1, 2'b10, 20'h13579, 20'h0000F);
      set_req(1, 1, 2'b00, 20'hFFFFF, 20'h0F00F);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         vectors++;
         if (bus.rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rmid_exec_rsp_%0d: rsp_valid=%b during reset, required 0", i, bus.rsp_valid);
         end
      end
      tick();
      rst_n = 1'b1;
      @(negedge clk);
      vectors++;
      if ({bus.req0_ready, bus.req1_ready, bus.rsp_valid} !== 3'b100) begin
         miscompares++;
         $display("FAIL rmid_exec_regrant: rdy0=%b rdy1=%b rsp_valid=%b, required 1 0 0",
                  bus.req0_ready, bus.req1_ready, bus.rsp_valid);
      end
      tick();
      set_req(0, 0, 2'b00, '0, '0);
      set_req(1, 0, 2'b00, '0, '0);
      drain();
      // Phase 2: last grant was req0; reset in RESP must still restore req0 priority.
      set_req(0, 1, 2'b11, 20'h0FFFF, 20'h00000);
      wait_ready(0, ok);
      tick();
      set_req(0, 0, 2'b00, '0, '0);
      wait_rsp(ok);
      vectors++;
      if (!ok) begin
         miscompares++;
         $display("FAIL rmid_resp_wait: rsp_valid=0 for 10 cycles, required 1");
      end
      tick();
      rst_n = 1'b0;
      set_req(0, 1, 2'b01, 20'h00100, 20'h00010);
      set_req(1, 1, 2'b10, 20'h55555, 20'h55555);
      @(negedge clk);
      vectors++;
      if (bus.rsp_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL rmid_resp_drop: rsp_valid=%b during reset, required 0", bus.rsp_valid);
      end
      tick();
      rst_n = 1'b1;
      @(negedge clk);
      vectors++;
      if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
         miscompares++;
         $display("FAIL rmid_resp_regrant: rdy0=%b rdy1=%b, required 1 0", bus.req0_ready, bus.req1_ready);
      end
      tick();
      set_req(0, 0, 2'b00, '0, '0);
      set_req(1, 0, 2'b00, '0, '0);
      drain();
   endtask

   initial begin
      rst_n = 1'b0;
      bus.rsp_ready = 1'b0;
      set_req(0, 0, 2'b00, '0, '0);
      set_req(1, 0, 2'b00, '0, '0);
      test_reset();
      test_xor();
      test_req1();
      test_fairness();
      test_backpressure();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end
endmodule
